// File: rtl/offset14_dac_pkg.sv
`default_nettype none
// =============================================================================
// Module   : offset14_dac_pkg
// Purpose  : Shared constants, FSM encoding and helpers for the offset14 SPI DAC TX
// Revision : 1.0 - initial release
// =============================================================================
package offset14_dac_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int SAMPLE_BITS = 14;
    localparam int UNDERRUN_W  = 16;

    localparam logic [1:0] DEFAULT_CMD_BITS = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } dac_state_t;

    function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
        return (&v) ? v : v + UNDERRUN_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/offset14_sample_fifo.sv
`default_nettype none
// =============================================================================
// Module   : offset14_sample_fifo
// Purpose  : Show-ahead synchronous FIFO with full/empty flags
// Revision : 1.0 - initial release
// =============================================================================
module offset14_sample_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_wr;
    logic             do_rd;

    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty   = (wr_ptr == rd_ptr);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/offset14_dac_spi_tx.sv
`default_nettype none
// =============================================================================
// Module   : offset14_dac_spi_tx
// Purpose  : Buffers offset-binary samples and serialises 16-bit SPI mode-0 frames
// Revision : 1.0 - initial release
// =============================================================================
module offset14_dac_spi_tx
    import offset14_dac_pkg::*;
#(
    parameter int         CLK_DIV    = 4,
    parameter int         FIFO_DEPTH = 4,
    parameter int         CS_GAP     = 4,
    parameter logic [1:0] CMD_BITS   = DEFAULT_CMD_BITS
) (
    input  logic                   aclk,
    input  logic                   rst_n,
    input  logic                   enable,
    input  logic [SAMPLE_BITS-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   dac_sclk,
    output logic                   dac_cs_n,
    output logic                   dac_sdi,
    output logic                   busy,
    output logic [UNDERRUN_W-1:0]  underrun_cnt
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int GAP_W = $clog2(CS_GAP + 1);
    localparam int TOG_W = $clog2(2 * FRAME_BITS);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
    localparam logic [TOG_W-1:0] TOG_LAST = TOG_W'(2 * FRAME_BITS - 1);

    dac_state_t             state;
    dac_state_t             next_state;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [SAMPLE_BITS-1:0] fifo_data;
    logic                   pop;
    logic                   primed;
    logic [SAMPLE_BITS-1:0] last_sample;
    logic [FRAME_BITS-1:0]  shift_reg;
    logic [FRAME_BITS-1:0]  load_frame;
    logic [DIV_W-1:0]       div_cnt;
    logic [TOG_W-1:0]       tog_cnt;
    logic [GAP_W-1:0]       gap_cnt;
    logic                   div_wrap;
    logic                   frame_done;
    logic                   gap_done;
    logic                   can_start;

    offset14_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (SAMPLE_BITS)
    ) u_fifo (
        .clk     (aclk),
        .rst_n   (rst_n),
        .wr_en   (s_valid),
        .wr_data (s_data),
        .rd_en   (pop),
        .rd_data (fifo_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign s_ready    = !fifo_full;
    assign busy       = (state != ST_IDLE);
    assign div_wrap   = (div_cnt == DIV_LAST);
    assign frame_done = div_wrap && (tog_cnt == TOG_LAST);
    assign gap_done   = (gap_cnt == GAP_LAST);
    // Repeating the last sample is only meaningful once one has been sent
    assign can_start  = enable && (!fifo_empty || primed);
    assign load_frame = {CMD_BITS, (fifo_empty ? last_sample : fifo_data)};

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE:  if (can_start) next_state = ST_LOAD;
            ST_LOAD: begin
                pop        = !fifo_empty;
                next_state = ST_SHIFT;
            end
            ST_SHIFT: if (frame_done) next_state = ST_GAP;
            ST_GAP:   if (gap_done) next_state = can_start ? ST_LOAD : ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge rst_n) begin
        if (!rst_n) begin
            dac_sclk     <= 1'b0;
            dac_cs_n     <= 1'b1;
            dac_sdi      <= 1'b0;
            underrun_cnt <= '0;
            primed       <= 1'b0;
            last_sample  <= '0;
            shift_reg    <= '0;
            div_cnt      <= '0;
            tog_cnt      <= '0;
            gap_cnt      <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (!fifo_empty) begin
                        last_sample <= fifo_data;
                        primed      <= 1'b1;
                    end else begin
                        underrun_cnt <= sat_inc(underrun_cnt);
                    end
                    shift_reg <= load_frame;
                    dac_sdi   <= load_frame[FRAME_BITS-1];
                    dac_cs_n  <= 1'b0;
                    dac_sclk  <= 1'b0;
                    div_cnt   <= '0;
                    tog_cnt   <= '0;
                end
                ST_SHIFT: begin
                    if (div_wrap) begin
                        div_cnt  <= '0;
                        dac_sclk <= !dac_sclk;
                        tog_cnt  <= tog_cnt + TOG_W'(1);
                        // Data changes only on falling edges so it is settled for the next rise
                        if (dac_sclk) begin
                            shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
                            dac_sdi   <= shift_reg[FRAME_BITS-2];
                        end
                        if (tog_cnt == TOG_LAST) begin
                            dac_cs_n <= 1'b1;
                            gap_cnt  <= '0;
                        end
                    end else begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end
                end
                ST_GAP:  gap_cnt <= gap_cnt + GAP_W'(1);
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/offset14_dac_spi_tx.md
Name: offset14_dac_spi_tx

Overview:
Downstream consumer of the float-to-offset14 stage in the sine wave generator. It accepts 14-bit offset-binary samples over a valid/ready handshake and buffers them in a small FIFO. Each sample is serialised to an external SPI DAC as a 16-bit frame (2 command bits + 14 data bits, MSB first, SPI mode 0). On FIFO underrun it repeats the last transmitted sample so the analog output never glitches.

Parameters:
- CLK_DIV, 4, aclk cycles per SCLK half-period; must be >=2.
- FIFO_DEPTH, 4, sample FIFO entries; must be a power of 2, >=2.
- CS_GAP, 4, aclk cycles dac_cs_n stays high between frames; must be >=1.
- CMD_BITS, 2'b00, command bits sent before the data.

Ports:
- aclk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- enable  in  1  allow new frames to start.
- s_data  in  14  offset-binary sample.
- s_valid  in  1  s_data valid.
- s_ready  out  1  FIFO can accept.
- dac_sclk  out  1  SPI clock; idles low.
- dac_cs_n  out  1  SPI chip select; active-low.
- dac_sdi  out  1  SPI data.
- busy  out  1  high when the FSM is not in IDLE.
- underrun_cnt  out  16  count of repeated-sample frames; saturates at 65535.

Behaviour:
- Clocking and reset: one clock, aclk. rst_n is asynchronous and active-low. All state is held in registers.
- Reset values:
  - s_ready=1, dac_sclk=0, dac_cs_n=1, dac_sdi=0, busy=0, underrun_cnt=0.
  - FIFO empty, primed=0, last_sample=0.
- Reset mid-frame: outputs take their reset values immediately (asynchronously). The partial frame is abandoned and the FIFO is emptied.
- FIFO write: occurs on s_valid && s_ready. s_ready = !full. When full, the write is refused and s_data is not consumed.
- FIFO pop: occurs only in the LOAD state. A write and a pop in the same cycle are both honoured.
- primed: set on the first pop and stays set until reset.
- FSM states:
  - IDLE: dac_cs_n=1, dac_sclk=0. Go to LOAD when enable && (!empty || primed).
  - LOAD (1 cycle):
    - If !empty: pop, and last_sample <= popped value.
    - Else: reuse last_sample and increment underrun_cnt (saturating).
    - shift_reg <= {CMD_BITS, sample}; dac_cs_n <= 0; dac_sdi <= bit 15. Go to SHIFT.
  - SHIFT:
    - A divider counts 0..CLK_DIV-1. On wrap, dac_sclk toggles.
    - On each falling-edge toggle, shift_reg shifts left and dac_sdi takes the next bit.
    - After 32 toggles (16 rising edges, last toggle leaves sclk=0): dac_cs_n <= 1 and go to GAP.
    - dac_cs_n low width = 32*CLK_DIV cycles (128 at default).
  - GAP: hold for CS_GAP cycles, then go to LOAD if enable (under the same condition as IDLE), else IDLE.
- Frame period, continuous streaming: 1 + 32*CLK_DIV + CS_GAP = 133 aclk cycles at default.
- dac_sdi timing: stable for a full SCLK half-period before each rising edge. The DAC samples on the rising edge.
- enable deasserted mid-frame: the current frame completes through GAP, then the FSM enters IDLE. enable is sampled only in IDLE and at the end of GAP.
- Before the first sample is ever received: no frames are sent, even with enable=1, and underrun_cnt does not increment.
- The block performs no arithmetic on data. Samples pass through bit-exact.

Decomposition:
- Shared package (offset14_dac_pkg):
  - FRAME_BITS=16, SAMPLE_BITS=14.
  - Default CMD_BITS.
  - FSM state encoding: IDLE, LOAD, SHIFT, GAP.
  - Underrun counter width (16).
- Sub-module offset14_sample_fifo: synchronous FIFO, DEPTH/WIDTH parameters, with full/empty flags and async active-low reset. The top level contains the FSM, divider, shifter and counters.

Test Plan:
- Reset, enable=1, push one sample 0x2000:
  - Exactly one LOAD, then frame bits 0010_0000_0000_0000 sampled on 16 rising sclk edges.
  - dac_cs_n low for 128 cycles.
  - Afterwards repeated frames of 0x2000 follow, and underrun_cnt increments once per repeat.
- Push 6 samples back-to-back (0x0000, 0x0001, 0x1FFF, 0x2000, 0x3FFE, 0x3FFF) with s_valid held:
  - s_ready drops while the FIFO holds 4 entries.
  - All 6 are transmitted in order, with no loss or duplication and underrun_cnt=0 until the FIFO drains.
- Continuous streaming with the FIFO kept non-empty:
  - Falling edges of dac_cs_n are exactly 133 cycles apart.
  - dac_cs_n high gap is 4 cycles.
- Drop enable during bit 7 of a frame: the frame completes all 16 bits, GAP runs, the FSM goes to IDLE with busy=0, and no further frames start.
- Assert rst_n=0 during SHIFT:
  - Same cycle: dac_cs_n=1, dac_sclk=0, busy=0.
  - After release with no new data: no frames are sent and underrun_cnt=0.
- Saturation: force underrun_cnt to 65534 via a long underrun run. The counter reaches 65535 and holds there across further repeats.
